router_port_arbiter: RTL and testbench
======================================

Name: router_port_arbiter

Overview:
- Per-output-port packet arbiter for the 3-port router (x, y, local). Sits between the routing algorithm and the output data_selector41 muxes.
- Each input presents a head/body/tail flit stream with a 2-bit destination. Each output port is locked to one input for a whole packet, chosen by round-robin.
- Drives the 2-bit mux selects (01 = x, 10 = y, 11 = local, 00 = none) plus per-input ready.
- Releases a port when the tail flit is accepted, when the port fails, or when the owner stalls too long.

Parameters:
- TIMEOUT, 16, consecutive owned cycles without a transfer before forced release. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  3  flit valid per input; bit0 = x, bit1 = y, bit2 = local
- in_dest  in  6  per-input destination: [1:0] x, [3:2] y, [5:4] local; 01 = x, 10 = y, 11 = local, 00 = invalid. Held stable for a whole packet.
- in_tail  in  3  current flit is the last of its packet
- in_ready  out  3  flit accepted this cycle when in_valid & in_ready
- out_ready  in  3  downstream FIFO of output port p can accept (p: 0 = x, 1 = y, 2 = local)
- fail  in  3  output port p is failed/unusable
- sel_x, sel_y, sel_local  out  2 each  registered mux select per output port
- out_valid  out  3  output port p carries a valid flit this cycle
- abort  out  3  one-cycle pulse: port p lock dropped by fail
- timeout  out  3  one-cycle pulse: port p lock dropped by timeout

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - all sel = 00; all ports IDLE; all owners cleared.
  - in_ready, out_valid, abort, timeout = 0; stall counters = 0.
  - round-robin pointer of each port = local, so x has top priority first.
- Per output port p, two-state FSM, IDLE / BUSY.
- Request definition: req[i][p] = in_valid[i] & (in_dest[i] == p+1). in_dest 00 never requests.
- IDLE behaviour:
  - If fail[p] = 0 and any req[.][p] is set, pick the first requester after the last winner, in order x → y → local → x.
  - At the next edge: owner = winner, sel_p = winner+1, state = BUSY, pointer = winner.
  - sel_p = 00 while IDLE.
- BUSY, combinational outputs:
  - in_ready[owner] = out_ready[p] & ~fail[p].
  - out_valid[p] = in_valid[owner] & in_ready[owner].
  - Transfer occurs when out_valid[p] = 1.
- BUSY, sequential updates:
  - Transfer with in_tail[owner]: next state IDLE, sel_p = 00.
  - fail[p] = 1: next state IDLE, sel_p = 00, abort[p] pulses for 1 cycle; the flit is not accepted.
  - No transfer: stall counter increments; on any transfer it clears.
  - TIMEOUT ≠ 0, counter = TIMEOUT-1 and no transfer this cycle: next state IDLE, sel_p = 00, timeout[p] pulses, counter cleared.
  - Precedence: fail > tail transfer > timeout.
- Latency:
  - Head flit valid in cycle N with port IDLE → sel valid and first transfer possible at N+1.
  - Tail accepted at M → IDLE at M+1 (one bubble) → next packet's first transfer possible at M+2.
- An input never owns two ports at once, since its destination is single-valued.
- in_ready[i] = 0 when input i owns no port.
- Simultaneous requests from all three inputs to different ports: all are granted in the same cycle, with no interaction.
- fail[p] held high in IDLE: no grant, sel_p stays 00, no abort pulse.
- Reset asserted mid-packet: immediate return to the reset state; the partial packet is abandoned with no abort pulse.
- Stall counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

Test Plan:
- Reset: rst_n = 0 with random inputs → all sel = 00, in_ready = 000, out_valid = 000, abort = 000, timeout = 000, asynchronously before the next edge.
- Single packet: x sends 3 flits to y (in_dest[1:0] = 10, tail on flit 3), out_ready = 111 → sel_y = 01 one cycle after valid; in_ready[0] high 3 cycles; sel_y = 00 the cycle after the tail.
- Round-robin: x, y and local all send continuous 1-flit packets to x after reset → sel_x sequence 01, 00, 10, 00, 11, 00, 01.
- Backpressure: during a y → local packet, out_ready[2] = 0 for 5 cycles (TIMEOUT = 16) → in_ready[1] = 0, out_valid[2] = 0, sel_local stays 10; the packet resumes afterwards with no flit loss.
- Fail mid-packet: local → x packet, fail[0] raised after flit 1 → abort[0] pulses once, sel_x = 00 next cycle, in_ready[2] = 0; no grant until fail[0] = 0.
- Timeout (TIMEOUT = 4): x owns port local, then drops in_valid[0] → exactly 4 stalled cycles, then timeout[2] pulses and sel_local = 00.

Source files
------------

// File: rtl/router_port_arbiter.sv
// router_port_arbiter
//
// Per-output-port packet arbiter for a 3-port router (x, y, local).
// Each output port is locked to one input for a whole packet (head to
// tail), chosen round-robin among the inputs requesting that port. The
// lock is dropped on tail acceptance, on port failure, or when the owner
// stalls for TIMEOUT consecutive cycles (TIMEOUT = 0 disables this).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid[2:0]       flit valid per input (0 = x, 1 = y, 2 = local)
//   in_dest[5:0]        2-bit destination per input (01 x, 10 y, 11 local)
//   in_tail[2:0]        current flit is the last of its packet
//   in_ready[2:0]       flit accepted when in_valid & in_ready
//   out_ready[2:0]      downstream of output port p can accept
//   fail[2:0]           output port p unusable
//   sel_x/y/local       registered mux select (01 x, 10 y, 11 local, 00 none)
//   out_valid[2:0]      output port p carries a valid flit this cycle
//   abort[2:0]          one-cycle pulse: lock dropped by fail
//   timeout[2:0]        one-cycle pulse: lock dropped by stall timeout

module router_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in_valid,
    input  logic [5:0] in_dest,
    input  logic [2:0] in_tail,
    output logic [2:0] in_ready,
    input  logic [2:0] out_ready,
    input  logic [2:0] fail,
    output logic [1:0] sel_x,
    output logic [1:0] sel_y,
    output logic [1:0] sel_local,
    output logic [2:0] out_valid,
    output logic [2:0] abort,
    output logic [2:0] timeout
);

    // Keep at least one bit so TIMEOUT = 0 still elaborates cleanly.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // First requester strictly after the last winner, wrapping x -> y -> local.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last) + k) % 3);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [2:0] rdy_vec [3];
    logic [1:0] sel_vec [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_port
            state_t        state_q, state_d;
            logic [1:0]    owner_q, owner_d;
            logic [1:0]    ptr_q, ptr_d;
            logic [1:0]    sel_q, sel_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          abort_q, abort_d;
            logic          tmo_q, tmo_d;
            logic [2:0]    req;
            logic          busy;
            logic          own_ok;
            logic          xfer;

            always_comb begin
                req = 3'b000;
                for (int i = 0; i < 3; i++) begin
                    req[i] = in_valid[i] & (in_dest[2*i +: 2] == 2'(gi + 1));
                end
            end

            assign busy   = (state_q == ST_BUSY);
            // Ready to the owner does not depend on its own valid.
            assign own_ok = busy & out_ready[gi] & ~fail[gi];
            assign xfer   = own_ok & in_valid[owner_q];

            assign rdy_vec[gi]    = own_ok ? (3'b001 << owner_q) : 3'b000;
            assign sel_vec[gi]    = sel_q;
            assign out_valid[gi]  = xfer;
            assign abort[gi]      = abort_q;
            assign timeout[gi]    = tmo_q;

            always_comb begin
                state_d = state_q;
                owner_d = owner_q;
                ptr_d   = ptr_q;
                sel_d   = sel_q;
                cnt_d   = cnt_q;
                abort_d = 1'b0;
                tmo_d   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (!fail[gi] && (req != 3'b000)) begin
                            state_d = ST_BUSY;
                            owner_d = rr_pick(req, ptr_q);
                            ptr_d   = rr_pick(req, ptr_q);
                            sel_d   = rr_pick(req, ptr_q) + 2'd1;
                            cnt_d   = '0;
                        end
                    end
                    ST_BUSY: begin
                        // Precedence: fail, then tail transfer, then timeout.
                        if (fail[gi]) begin
                            state_d = ST_IDLE;
                            sel_d   = 2'b00;
                            cnt_d   = '0;
                            abort_d = 1'b1;
                        end else if (xfer && in_tail[owner_q]) begin
                            state_d = ST_IDLE;
                            sel_d   = 2'b00;
                            cnt_d   = '0;
                        end else if (xfer) begin
                            cnt_d = '0;
                        end else if ((TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1)) begin
                            state_d = ST_IDLE;
                            sel_d   = 2'b00;
                            cnt_d   = '0;
                            tmo_d   = 1'b1;
                        end else if (cnt_q != {CW{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        sel_d   = 2'b00;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    owner_q <= 2'd0;
                    ptr_q   <= 2'd2;   // local, so x wins the first contest
                    sel_q   <= 2'b00;
                    cnt_q   <= '0;
                    abort_q <= 1'b0;
                    tmo_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    owner_q <= owner_d;
                    ptr_q   <= ptr_d;
                    sel_q   <= sel_d;
                    cnt_q   <= cnt_d;
                    abort_q <= abort_d;
                    tmo_q   <= tmo_d;
                end
            end
        end
    endgenerate

    // An input targets a single port, so at most one term is ever set.
    assign in_ready  = rdy_vec[0] | rdy_vec[1] | rdy_vec[2];
    assign sel_x     = sel_vec[0];
    assign sel_y     = sel_vec[1];
    assign sel_local = sel_vec[2];

endmodule

// File: tb/tb_router_port_arbiter.sv
module tb_router_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_valid;
    logic [5:0] in_dest;
    logic [2:0] in_tail;
    logic [2:0] out_ready;
    logic [2:0] fail;

    // Index 0: TIMEOUT = 16 instance, index 1: TIMEOUT = 4 instance.
    logic [2:0] rdy [2];
    logic [2:0] ov  [2];
    logic [2:0] ab  [2];
    logic [2:0] tm  [2];
    logic [1:0] sx  [2];
    logic [1:0] sy  [2];
    logic [1:0] sl  [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    router_port_arbiter #(.TIMEOUT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dest(in_dest),
        .in_tail(in_tail), .in_ready(rdy[0]), .out_ready(out_ready), .fail(fail),
        .sel_x(sx[0]), .sel_y(sy[0]), .sel_local(sl[0]),
        .out_valid(ov[0]), .abort(ab[0]), .timeout(tm[0])
    );

    router_port_arbiter #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dest(in_dest),
        .in_tail(in_tail), .in_ready(rdy[1]), .out_ready(out_ready), .fail(fail),
        .sel_x(sx[1]), .sel_y(sy[1]), .sel_local(sl[1]),
        .out_valid(ov[1]), .abort(ab[1]), .timeout(tm[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each port: owner (-1 = free), last winner, consecutive stall count,
    // and the pulses that become visible the cycle after a forced release.
    int m_own [2][3];
    int m_ptr [2][3];
    int m_cnt [2][3];
    bit m_ab  [2][3];
    bit m_to  [2][3];
    int to_lim [2] = '{16, 4};

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 3; p++) begin
                m_own[k][p] = -1;
                m_ptr[k][p] = 2;
                m_cnt[k][p] = 0;
                m_ab[k][p]  = 0;
                m_to[k][p]  = 0;
            end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int k = 0; k < 2; k++) begin
                    for (int p = 0; p < 3; p++) begin
                        m_ab[k][p] = 0;
                        m_to[k][p] = 0;
                        if (m_own[k][p] < 0) begin
                            if (!fail[p]) begin
                                bit found;
                                found = 0;
                                for (int j = 1; j <= 3; j++) begin
                                    int c;
                                    c = (m_ptr[k][p] + j) % 3;
                                    if (!found && in_valid[c] && (int'(in_dest[2*c +: 2]) == p + 1)) begin
                                        found = 1;
                                        m_own[k][p] = c;
                                        m_ptr[k][p] = c;
                                        m_cnt[k][p] = 0;
                                    end
                                end
                            end
                        end else begin
                            int  o;
                            bit  moved;
                            o = m_own[k][p];
                            moved = in_valid[o] && out_ready[p];
                            if (fail[p]) begin
                                m_own[k][p] = -1;
                                m_ab[k][p]  = 1;
                            end else if (moved && in_tail[o]) begin
                                m_own[k][p] = -1;
                            end else if (moved) begin
                                m_cnt[k][p] = 0;
                            end else begin
                                m_cnt[k][p]++;
                                if (to_lim[k] != 0 && m_cnt[k][p] == to_lim[k]) begin
                                    m_own[k][p] = -1;
                                    m_to[k][p]  = 1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [2:0] e_rdy, e_ov, e_ab, e_tm;
                logic [5:0] e_sel;
                e_rdy = '0; e_ov = '0; e_ab = '0; e_tm = '0; e_sel = '0;
                for (int p = 0; p < 3; p++) begin
                    int o;
                    o = m_own[k][p];
                    e_ab[p] = m_ab[k][p];
                    e_tm[p] = m_to[k][p];
                    if (o >= 0) begin
                        e_sel[2*p +: 2] = 2'(o + 1);
                        if (out_ready[p] && !fail[p]) begin
                            e_rdy[o] = 1'b1;
                            e_ov[p]  = in_valid[o];
                        end
                    end
                end
                chk($sformatf("model_sel[%0d]", k), {sl[k], sy[k], sx[k]}, e_sel);
                chk($sformatf("model_rdy[%0d]", k), rdy[k], e_rdy);
                chk($sformatf("model_ov[%0d]", k), ov[k], e_ov);
                chk($sformatf("model_abort[%0d]", k), ab[k], e_ab);
                chk($sformatf("model_tmo[%0d]", k), tm[k], e_tm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = '0; in_dest = '0; in_tail = '0; out_ready = 3'b111; fail = '0;
    endtask

    task automatic idle_cycles(input int n);
        idle_in();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int acc;
        int nab;
        int ntm;
        logic [1:0] rr_exp [7];
        rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01};

        // Reset with random inputs: outputs clear without any clock edge.
        rst_n = 1'b0;
        idle_in();
        #2;
        in_valid = 3'($urandom); in_dest = 6'($urandom); in_tail = 3'($urandom);
        out_ready = 3'($urandom); fail = 3'($urandom);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_sel", {sl[k], sy[k], sx[k]}, 6'b0);
            chk("rst_rdy", rdy[k], 3'b000);
            chk("rst_ov", ov[k], 3'b000);
            chk("rst_ab", ab[k], 3'b000);
            chk("rst_tm", tm[k], 3'b000);
        end
        tick();
        idle_in();
        tick();
        rst_n = 1'b1;
        idle_cycles(2);

        // Single packet x -> y, three flits.
        in_valid = 3'b001; in_dest = 6'b000010; in_tail = 3'b000;
        #1;
        chk("sp_sel_idle", sy[0], 2'b00);
        chk("sp_rdy_idle", rdy[0][0], 1'b0);
        acc = 0;
        tick(); #1;
        chk("sp_sel", sy[0], 2'b01);
        acc += int'(in_valid[0] & rdy[0][0]);
        tick(); #1;
        acc += int'(in_valid[0] & rdy[0][0]);
        tick(); in_tail = 3'b001; #1;
        chk("sp_ov_tail", ov[0][1], 1'b1);
        acc += int'(in_valid[0] & rdy[0][0]);
        tick(); idle_in(); #1;
        chk("sp_sel_after", sy[0], 2'b00);
        acc += int'(in_valid[0] & rdy[0][0]);
        chk("sp_flits", acc, 3);
        idle_cycles(4);

        // Round robin: all inputs send 1-flit packets to x.
        in_valid = 3'b111; in_dest = 6'b010101; in_tail = 3'b111;
        #1;
        chk("rr_sel0", sx[0], 2'b00);
        for (int j = 0; j < 7; j++) begin
            tick(); #1;
            chk($sformatf("rr_sel%0d", j + 1), sx[0], rr_exp[j]);
            chk($sformatf("rr4_sel%0d", j + 1), sx[1], rr_exp[j]);
        end
        idle_cycles(4);

        // Backpressure on y -> local, four flits, five stalled cycles.
        in_valid = 3'b010; in_dest = 6'b001100; in_tail = 3'b000;
        #1;
        chk("bp_sel_idle", sl[0], 2'b00);
        acc = 0;
        tick(); #1;
        chk("bp_sel", sl[0], 2'b10);
        acc += int'(in_valid[1] & rdy[0][1]);
        for (int j = 0; j < 5; j++) begin
            tick(); out_ready = 3'b011; #1;
            chk("bp_rdy_low", rdy[0][1], 1'b0);
            chk("bp_ov_low", ov[0][2], 1'b0);
            chk("bp_sel_hold", sl[0], 2'b10);
            acc += int'(in_valid[1] & rdy[0][1]);
        end
        tick(); out_ready = 3'b111; #1;
        acc += int'(in_valid[1] & rdy[0][1]);
        tick(); #1;
        acc += int'(in_valid[1] & rdy[0][1]);
        tick(); in_tail = 3'b010; #1;
        acc += int'(in_valid[1] & rdy[0][1]);
        tick(); idle_in(); #1;
        chk("bp_sel_after", sl[0], 2'b00);
        chk("bp_flits", acc, 4);
        idle_cycles(6);

        // Fail mid-packet on local -> x.
        in_valid = 3'b100; in_dest = 6'b010000; in_tail = 3'b000;
        #1;
        chk("fl_sel_idle", sx[0], 2'b00);
        tick(); #1;
        chk("fl_sel", sx[0], 2'b11);
        chk("fl_rdy1", rdy[0][2], 1'b1);
        nab = 0;
        tick(); fail = 3'b001; #1;
        chk("fl_rdy_fail", rdy[0][2], 1'b0);
        chk("fl_ov_fail", ov[0][0], 1'b0);
        nab += int'(ab[0][0]);
        tick(); #1;
        chk("fl_sel_drop", sx[0], 2'b00);
        chk("fl_abort", ab[0][0], 1'b1);
        chk("fl_rdy_drop", rdy[0][2], 1'b0);
        nab += int'(ab[0][0]);
        for (int j = 0; j < 2; j++) begin
            tick(); #1;
            chk("fl_sel_held", sx[0], 2'b00);
            nab += int'(ab[0][0]);
        end
        chk("fl_abort_once", nab, 1);
        tick(); fail = 3'b000; #1;
        chk("fl_sel_nogrant", sx[0], 2'b00);
        tick(); in_tail = 3'b100; #1;
        chk("fl_regrant", sx[0], 2'b11);
        chk("fl_rdy_regrant", rdy[0][2], 1'b1);
        tick(); idle_in(); #1;
        chk("fl_sel_end", sx[0], 2'b00);
        idle_cycles(4);

        // Timeout: x owns local then goes silent.
        in_valid = 3'b001; in_dest = 6'b000011; in_tail = 3'b000;
        tick(); #1;
        chk("to_sel", sl[1], 2'b01);
        chk("to_rdy", rdy[1][0], 1'b1);
        ntm = 0;
        tick(); in_valid = 3'b000; #1;
        for (int j = 0; j < 4; j++) begin
            chk("to_sel_hold", sl[1], 2'b01);
            chk("to_no_pulse", tm[1][2], 1'b0);
            ntm += int'(tm[0][2]);
            tick(); #1;
        end
        chk("to_pulse", tm[1][2], 1'b1);
        chk("to_sel_drop", sl[1], 2'b00);
        ntm += int'(tm[0][2]);
        tick(); #1;
        chk("to_pulse_end", tm[1][2], 1'b0);
        for (int j = 0; j < 18; j++) begin
            ntm += int'(tm[0][2]);
            tick(); #1;
        end
        chk("to16_pulses", ntm, 1);
        chk("to16_sel_drop", sl[0], 2'b00);
        idle_cycles(2);

        // Concurrent grants, then reset mid-packet.
        in_valid = 3'b111; in_dest = 6'b011110; in_tail = 3'b000;
        tick(); #1;
        chk("cc_sel", {sl[0], sy[0], sx[0]}, {2'b10, 2'b01, 2'b11});
        chk("cc_rdy", rdy[0], 3'b111);
        chk("cc_ov", ov[0], 3'b111);
        tick(); #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mr_sel", {sl[k], sy[k], sx[k]}, 6'b0);
            chk("mr_rdy", rdy[k], 3'b000);
            chk("mr_ab", ab[k], 3'b000);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick(); tick();
        idle_cycles(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
